// File: rtl/lif_pkg.sv
// rtl/lif_pkg.sv - shared width, threshold reset value and scheduler FSM encoding
package lif_pkg;

  localparam int LIF_W             = 8;
  localparam int LIF_THRESHOLD_RST = 127;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } lif_sched_state_t;

endpackage

// File: rtl/lif_core.sv
// rtl/lif_core.sv - combinational leaky-integrate-and-fire update for one neuron
module lif_core
  import lif_pkg::*;
#(
  parameter int W = LIF_W
) (
  input  logic [W-1:0] state,
  input  logic [W-1:0] current,
  input  logic [W-1:0] threshold,
  output logic [W-1:0] next_state,
  output logic         spike
);

  // A firing neuron drops its old potential entirely; otherwise it leaks by half.
  assign spike      = (state >= threshold);
  assign next_state = current + (spike ? '0 : (state >> 1));

endmodule

// File: rtl/lif_tdm_scheduler.sv
// rtl/lif_tdm_scheduler.sv - sweeps N virtual neurons through one shared LIF datapath
module lif_tdm_scheduler
  import lif_pkg::*;
#(
  parameter int N_NEURONS = 4,
  parameter int W         = LIF_W,
  parameter int IDX_W     = $clog2(N_NEURONS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cfg_we,
  input  logic [W-1:0]     cfg_threshold,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] in_idx,
  input  logic [W-1:0]     in_current,
  output logic             spike_valid,
  output logic [IDX_W-1:0] spike_idx,
  output logic             spike,
  output logic [W-1:0]     state_out,
  output logic             busy,
  output logic             done
);

  lif_sched_state_t fsm_q;
  logic [W-1:0]     mem_q [N_NEURONS];
  logic [W-1:0]     threshold_q;
  logic [W-1:0]     core_next;
  logic             core_spike;
  logic             accept;
  logic             last;

  assign in_ready = (fsm_q == RUN);
  assign busy     = (fsm_q != IDLE);
  assign done     = (fsm_q == DONE);
  assign accept   = in_valid && in_ready;
  assign last     = (in_idx == IDX_W'(N_NEURONS - 1));

  lif_core #(.W(W)) u_core (
    .state      (mem_q[in_idx]),
    .current    (in_current),
    .threshold  (threshold_q),
    .next_state (core_next),
    .spike      (core_spike)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_q       <= IDLE;
      threshold_q <= W'(LIF_THRESHOLD_RST);
      in_idx      <= '0;
      spike_valid <= 1'b0;
      spike_idx   <= '0;
      spike       <= 1'b0;
      state_out   <= '0;
      for (int i = 0; i < N_NEURONS; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      spike_valid <= accept;
      case (fsm_q)
        IDLE: begin
          // Threshold lands on the same edge as start, so the new sweep sees it.
          if (cfg_we) begin
            threshold_q <= cfg_threshold;
          end
          if (start) begin
            fsm_q  <= RUN;
            in_idx <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            mem_q[in_idx] <= core_next;
            spike_idx     <= in_idx;
            spike         <= core_spike;
            state_out     <= core_next;
            if (last) begin
              fsm_q  <= DONE;
              in_idx <= '0;
            end else begin
              in_idx <= in_idx + IDX_W'(1);
            end
          end
        end
        DONE: begin
          fsm_q <= IDLE;
        end
        default: begin
          fsm_q <= IDLE;
        end
      endcase
    end
  end

endmodule
